// File: rtl/pipeline_types.sv
// Shared types and default timing for the single-wire pulse-width link.
// Both the transmit encoder and the receive-side edge timer take their
// T0H/T1H/TBIT values from here so the two ends always agree.
//   tx_state_t      : transmit FSM states
//   DEF_*           : default timing constants, in clock cycles
//   DEF_RX_T_SPLIT  : receive threshold; a high time at or above it decodes as 1
package pipeline_types;

    localparam int DEF_WIDTH      = 12;
    localparam int DEF_DATA_W     = 24;
    localparam int DEF_T0H        = 20;
    localparam int DEF_T1H        = 40;
    localparam int DEF_TBIT       = 63;
    localparam int DEF_TRESET     = 2600;

    // Receiver splits the 0/1 decision halfway between the two high times.
    localparam int DEF_RX_T_SPLIT = (DEF_T0H + DEF_T1H) / 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_HIGH  = 2'd1,
        TX_LOW   = 2'd2,
        TX_LATCH = 2'd3
    } tx_state_t;

endpackage

// File: rtl/pulse_encoder_phase_timer.sv
// phase_timer: loadable down-counter that times each phase of the output line.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_load           : load i_load_val this cycle (takes priority over counting)
//   i_load_val       : value to load; the phase then lasts i_load_val+1 cycles
//   o_zero           : counter is at zero (the final cycle of the current phase)
// The counter holds at zero instead of wrapping.
module phase_timer #(
    parameter int WIDTH = 12
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule

// File: rtl/pulse_encoder.sv
// pulse_encoder: turns parallel pixel words into a pulse-width-coded
// single-wire stream. Each bit is one TBIT-cycle period, high for T1H (1) or
// T0H (0) cycles, sent MSB first. A frame's last word is followed by TRESET
// low cycles (latch).
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_data, i_last   : word to send and end-of-frame flag, sampled at accept
//   i_valid, o_ready : input handshake
//   o_dout           : registered serial line
//   o_busy           : any state other than IDLE
//   o_state_dbg      : current FSM state, for observation
// Handshake: a word transfers on every rising edge where i_valid && o_ready.
// o_ready depends only on internal state, never on i_valid. It is high in
// IDLE and in the final LOW cycle of bit 0 of a non-last word, so a following
// word can start with no idle cycle in between.
module pulse_encoder
    import pipeline_types::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int T0H    = DEF_T0H,
    parameter int T1H    = DEF_T1H,
    parameter int TBIT   = DEF_TBIT,
    parameter int TRESET = DEF_TRESET
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_dout,
    output logic              o_busy,
    output tx_state_t         o_state_dbg
);

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TBIT <= 2 ** WIDTH &&
          TRESET > 0 && TRESET <= 2 ** WIDTH && DATA_W >= 2)) begin : g_bad_params
        $error("pulse_encoder: illegal timing parameters");
    end

    localparam int IDX_W = $clog2(DATA_W);

    // Timer reload values are one less than the phase length.
    localparam logic [WIDTH-1:0] T0H_M1    = WIDTH'(T0H - 1);
    localparam logic [WIDTH-1:0] T1H_M1    = WIDTH'(T1H - 1);
    localparam logic [WIDTH-1:0] T0L_M1    = WIDTH'(TBIT - T0H - 1);
    localparam logic [WIDTH-1:0] T1L_M1    = WIDTH'(TBIT - T1H - 1);
    localparam logic [WIDTH-1:0] TRESET_M1 = WIDTH'(TRESET - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;
    logic              dout_q;

    logic              tmr_load;
    logic [WIDTH-1:0]  tmr_val;
    logic              tmr_zero;
    logic              ready;

    phase_timer #(.WIDTH(WIDTH)) u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .o_zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        last_d   = last_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        ready    = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                ready = 1'b1;
            end
            TX_HIGH: begin
                if (tmr_zero) begin
                    // Low time is the remainder of the bit period.
                    tmr_load = 1'b1;
                    tmr_val  = shift_q[DATA_W-1] ? T1L_M1 : T0L_M1;
                    state_d  = TX_LOW;
                end
            end
            TX_LOW: begin
                if (tmr_zero) begin
                    if (idx_q != '0) begin
                        // Next bit sits just below the current MSB.
                        shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                        idx_d    = idx_q - IDX_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = shift_q[DATA_W-2] ? T1H_M1 : T0H_M1;
                        state_d  = TX_HIGH;
                    end else if (last_q) begin
                        tmr_load = 1'b1;
                        tmr_val  = TRESET_M1;
                        state_d  = TX_LATCH;
                    end else begin
                        // Offer a gap-free continuation; without a word the
                        // line simply idles low and no latch is sent.
                        ready   = 1'b1;
                        state_d = TX_IDLE;
                    end
                end
            end
            TX_LATCH: begin
                if (tmr_zero) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        // Accept overrides whatever the state above decided.
        if (ready && i_valid) begin
            shift_d  = i_data;
            last_d   = i_last;
            idx_d    = IDX_MAX;
            tmr_load = 1'b1;
            tmr_val  = i_data[DATA_W-1] ? T1H_M1 : T0H_M1;
            state_d  = TX_HIGH;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            // Registered from the next state so the line rises on the same
            // edge that enters HIGH.
            dout_q  <= (state_d == TX_HIGH);
        end
    end

    assign o_ready     = ready;
    assign o_dout      = dout_q;
    assign o_busy      = (state_q != TX_IDLE);
    assign o_state_dbg = state_q;

endmodule

// File: tb/tb_pulse_encoder.sv
module tb_pulse_encoder;
    import pipeline_types::*;

    localparam int DW     = DEF_DATA_W;
    localparam int T0H    = DEF_T0H;
    localparam int T1H    = DEF_T1H;
    localparam int TBIT   = DEF_TBIT;
    localparam int TRESET = DEF_TRESET;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_last = 1'b0;
    logic          i_valid = 1'b0;
    logic          ready, dout, busy;
    tx_state_t     st;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_encoder dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_data      (i_data),
        .i_last      (i_last),
        .i_valid     (i_valid),
        .o_ready     (ready),
        .o_dout      (dout),
        .o_busy      (busy),
        .o_state_dbg (st)
    );

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_mis = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_q[$];
    int            rx_rd = 0;
    logic          trace_q[$];
    logic          rdy_q[$];
    logic          exp_wave[$];
    int            latch_cnt = 0;

    // ---------------- receive-side decoder model ----------------
    // Measures every high pulse and classifies it as a 0 or 1 bit; bits
    // within a word must start exactly TBIT cycles apart.
    int            bad_pulse = 0;
    int            bad_period = 0;
    initial begin
        logic          prev;
        logic          b;
        int            hi_len;
        int            bit_cnt;
        int            last_rise;
        logic [DW-1:0] acc_w;
        prev = 1'b0; hi_len = 0; bit_cnt = 0; last_rise = 0; acc_w = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0; hi_len = 0; bit_cnt = 0;
            end else begin
                if (dout) begin
                    if (!prev) begin
                        if (bit_cnt != 0 && (cyc - last_rise) != TBIT) bad_period++;
                        last_rise = cyc;
                    end
                    hi_len++;
                end else if (prev) begin
                    b = 1'b0;
                    if (hi_len == T1H) b = 1'b1;
                    else if (hi_len != T0H) bad_pulse++;
                    acc_w = {acc_w[DW-2:0], b};
                    bit_cnt++;
                    if (bit_cnt == DW) begin
                        rx_q.push_back(acc_w);
                        bit_cnt = 0;
                    end
                    hi_len = 0;
                end
                prev = dout;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_trace();
        trace_q.delete();
        rdy_q.delete();
        latch_cnt = 0;
    endtask

    // Record the current cycle's outputs, then advance one cycle.
    task automatic step();
        trace_q.push_back(dout);
        rdy_q.push_back(ready);
        if (st == TX_LATCH) latch_cnt++;
        @(negedge clk);
    endtask

    // Offer a word and return at the negedge of the first cycle after accept.
    task automatic push_word(input logic [DW-1:0] w, input logic l, input bit clr, output int acc);
        int guard = 0;
        i_data  = w;
        i_last  = l;
        i_valid = 1'b1;
        while (!ready && guard < 10000) begin
            step();
            guard++;
        end
        if (!ready) check("push_timeout", 32'(ready), 32'd1);
        acc = cyc + 1;
        exp_q.push_back(w);
        if (clr) begin
            clear_trace();
            @(negedge clk);
        end else begin
            step();
        end
    endtask

    // Run until o_busy drops; drop_n is that cycle counted from accept (k+1 = 1).
    task automatic wait_idle(input int acc, output int drop_n);
        int guard = 0;
        while (busy && guard < 20000) begin
            step();
            guard++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
        drop_n = cyc - acc + 1;
    endtask

    // Ideal line waveform for one word, straight from the bit-period rules.
    function automatic void build_wave(input logic [DW-1:0] w, input bit with_latch);
        for (int b = DW - 1; b >= 0; b--) begin
            int h;
            h = w[b] ? T1H : T0H;
            for (int c = 0; c < TBIT; c++) exp_wave.push_back(c < h);
        end
        if (with_latch) for (int c = 0; c < TRESET; c++) exp_wave.push_back(1'b0);
    endfunction

    task automatic compare_wave(input string tag);
        int bad = 0;
        int n;
        n = (trace_q.size() < exp_wave.size()) ? trace_q.size() : exp_wave.size();
        for (int i = 0; i < n; i++) if (trace_q[i] !== exp_wave[i]) bad++;
        check({tag, "_wave_len"}, 32'(trace_q.size()), 32'(exp_wave.size()));
        check({tag, "_wave_bad_cycles"}, 32'(bad), 32'd0);
    endtask

    function automatic int ready_count();
        int c = 0;
        foreach (rdy_q[i]) if (rdy_q[i]) c++;
        return c;
    endfunction

    task automatic compare_rx(input string tag);
        check({tag, "_nwords"}, 32'(rx_q.size() - rx_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (rx_rd < rx_q.size()) begin
                check({tag, "_word"}, 32'(rx_q[rx_rd]), 32'(e));
                rx_rd++;
            end
        end
        rx_rd = rx_q.size();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int            acc, acc_b, drop, hi_seen, guard;
        logic [DW-1:0] w;
        logic          l;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hold_dout", 32'(dout), 32'd0);
        check("rst_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_state", 32'(st), 32'(TX_IDLE));

        // Reset in the middle of a HIGH phase
        push_word(24'h5A5A5A, 1'b1, 1'b1, acc);
        i_valid = 1'b0;
        repeat (4) step();
        check("midhigh_dout_before", 32'(dout), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("midhigh_async_dout", 32'(dout), 32'd0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midhigh_ready_after", 32'(ready), 32'd1);
        check("midhigh_busy_after", 32'(busy), 32'd0);
        hi_seen = 0;
        repeat (10) begin
            if (dout) hi_seen++;
            @(negedge clk);
        end
        check("midhigh_line_idle", 32'(hi_seen), 32'd0);
        check("midhigh_no_word", 32'(rx_q.size()), 32'(rx_rd));

        // Single word with latch
        exp_wave.delete();
        push_word(24'h800001, 1'b1, 1'b1, acc);
        i_valid = 1'b0;
        wait_idle(acc, drop);
        check("single_busy_drop", 32'(drop), 32'(DW * TBIT + TRESET + 1));
        build_wave(24'h800001, 1'b1);
        compare_wave("single");
        if (trace_q.size() > 40) begin
            check("single_last_high_cycle", 32'(trace_q[39]), 32'd1);
            check("single_first_low_cycle", 32'(trace_q[40]), 32'd0);
        end
        check("single_ready_cycles", 32'(ready_count()), 32'd0);
        check("single_latch_len", 32'(latch_cnt), 32'(TRESET));
        compare_rx("single");

        // Two words back to back, valid held
        exp_wave.delete();
        push_word(24'hFFFFFF, 1'b0, 1'b1, acc);
        push_word(24'h000000, 1'b1, 1'b0, acc_b);
        i_valid = 1'b0;
        check("b2b_second_accept", 32'(acc_b - acc), 32'(DW * TBIT));
        wait_idle(acc, drop);
        check("b2b_busy_drop", 32'(drop), 32'(2 * DW * TBIT + TRESET + 1));
        build_wave(24'hFFFFFF, 1'b0);
        build_wave(24'h000000, 1'b1);
        compare_wave("b2b");
        check("b2b_ready_cycles", 32'(ready_count()), 32'd1);
        compare_rx("b2b");

        // Underrun: non-last word, nothing follows
        exp_wave.delete();
        push_word(24'hAAAAAA, 1'b0, 1'b1, acc);
        i_valid = 1'b0;
        wait_idle(acc, drop);
        check("under_busy_drop", 32'(drop), 32'(DW * TBIT + 1));
        check("under_no_latch", 32'(latch_cnt), 32'd0);
        check("under_ready_idle", 32'(ready), 32'd1);
        check("under_ready_cycles", 32'(ready_count()), 32'd1);
        build_wave(24'hAAAAAA, 1'b0);
        compare_wave("under");
        compare_rx("under");

        // Stall: inputs wiggle while a word is in flight, then valid waits out the latch
        push_word(24'h123456, 1'b1, 1'b1, acc);
        check("stall_ready_in_high", 32'(ready), 32'd0);
        i_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            i_data = DW'($urandom);
            i_last = 1'($urandom_range(0, 1));
            step();
        end
        i_data  = 24'hC3A50F;
        i_last  = 1'b1;
        i_valid = 1'b1;
        guard = 0;
        while (!ready && guard < 10000) begin
            step();
            guard++;
        end
        check("stall_latch_seen", 32'(latch_cnt), 32'(TRESET));
        acc_b = cyc + 1;
        check("stall_accept_cycle", 32'(acc_b - acc), 32'(DW * TBIT + TRESET + 1));
        exp_q.push_back(24'hC3A50F);
        clear_trace();
        @(negedge clk);
        i_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            i_data = DW'($urandom);
            step();
        end
        wait_idle(acc_b, drop);
        exp_wave.delete();
        build_wave(24'hC3A50F, 1'b1);
        compare_wave("stall");
        compare_rx("stall");

        // Random stream with random last flags and gaps
        for (int i = 0; i < 16; i++) begin
            w = DW'($urandom);
            l = (i == 15) || ($urandom_range(0, 3) == 0);
            push_word(w, l, 1'b1, acc);
            if (i == 15 || $urandom_range(0, 1) == 0) begin
                i_valid = 1'b0;
                wait_idle(acc, drop);
                check("rand_busy_drop", 32'(drop), 32'(DW * TBIT + (l ? TRESET : 0) + 1));
                repeat ($urandom_range(0, 4)) step();
            end
        end
        i_valid = 1'b0;
        compare_rx("rand");

        check("decoder_bad_pulses", 32'(bad_pulse), 32'd0);
        check("decoder_bad_periods", 32'(bad_period), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
